debug_display_scanner: RTL and testbench
========================================

# debug_display_scanner

Parametrised successor to the single-shot register/memory 7-segment viewer in the MIPS register-file debug path. Selects register file or data memory as source, issues its own synchronous read, and snapshots the result into a display buffer. Drives a multiplexed N-digit common-anode display showing address plus data. Adds auto-stepping through addresses, freeze, and configurable scan timing.

## Interface
- DIGITS, 8: number of 7-segment digits; the top 2 show the address, the rest show data (≥3).
- MEM_AW, 6: memory address width.
- REG_AW, 5: register address width (≤ MEM_AW).
- DATA_W, 32: read data width.
- SCAN_DIV, 50000: clk cycles per digit slot.
- REFRESH, 1000000: clk cycles between buffer re-reads while holding.
- AUTO_TICKS, 50000000: clk cycles per address step in auto mode.
- clk in 1: single clock; all state on rising edge.
- clr in 1: reset, asynchronous, active-low.
- ShowMem in 1: 0 = register file, 1 = data memory.
- Auto in 1: 1 = step address automatically, 0 = use Addr.
- Freeze in 1: 1 = hold buffer and address.
- Addr in MEM_AW: manual address; only low REG_AW bits are used in register mode.
- RegData in DATA_W: register file read data, valid 1 cycle after ReadReg.
- MemData in DATA_W: memory read data, valid 1 cycle after ReadMem.
- ReadReg out REG_AW: register read address.
- ReadMem out MEM_AW: memory read address.
- CurAddr out MEM_AW: address currently shown.
- a2g out 7: segments g..a, active-low.
- an out DIGITS: digit enables, one-hot active-low.
- dp out 1: decimal point, active-low.

## Operation
- Address source: in manual mode, cur = Addr (masked to REG_AW in register mode). In auto mode, cur increments by 1 every AUTO_TICKS cycles. It wraps at 2^REG_AW−1 → 0 in register mode and at 2^MEM_AW−1 → 0 in memory mode.
- A ShowMem change, or Auto rising, clears the auto address to 0 and restarts the auto counter.
- Snapshot FSM states: HOLD, ISSUE, CAPTURE.
  - HOLD → ISSUE when cur changes, ShowMem changes, or the refresh counter hits REFRESH−1, and Freeze=0.
  - ISSUE → CAPTURE unconditionally.
  - CAPTURE → HOLD unconditionally.
- ISSUE drives the selected read port with the latched address; the unselected port is driven to 0. CAPTURE loads the buffer from the selected data and the address.
- A trigger arriving during ISSUE or CAPTURE is held pending and services on the next HOLD cycle.
- Freeze=1: the auto counter and refresh counter stall, no new ISSUE starts, and any in-flight sequence completes. Scanning continues.
- Digit content:
  - digit i < DIGITS−2 shows nibble i of the buffered data; nibbles above DATA_W show 0.
  - digits DIGITS−2 and DIGITS−1 show the low and high nibble of the buffered address.
- dp is low only on digit DIGITS−2 when the buffered source is memory.
- Scan: the prescaler counts 0..SCAN_DIV−1. On wrap, the digit index advances and wraps from DIGITS−1 to 0. an is low at the active digit only. Segments are registered together with an, so there is no ghosting.

## Timing
- Reset values:
  - State: HOLD; buffer 0; cur 0; all counters 0; digit index 0.
  - Outputs: ReadReg 0, ReadMem 0, CurAddr 0, an all ones, a2g 7'h7F, dp 1.
- The first scan output appears 1 cycle after reset release: an[0]=0, showing "0".
- Latency from Addr change (manual, Freeze=0) to buffer update is 3 edges: HOLD detect, ISSUE, CAPTURE. CurAddr follows cur with 1 cycle latency.
- Read data is sampled exactly 1 cycle after the address is presented (CAPTURE edge).
- Reset mid-sequence aborts to HOLD immediately; no partial buffer write.
- Simultaneous auto step and refresh trigger: a single ISSUE using the new address.

## Configuration
- DISPLAY_BLANK_EN defined: leading-zero data digits are blanked (a2g 7'h7F, an still cycles). The least significant data digit and both address digits are never blanked.
- Undefined: all digits are always shown, with zeros displayed.

## Structure
- Shared package display_pkg holds:
  - the FSM state enum (HOLD/ISSUE/CAPTURE);
  - the 16-entry hex-to-segment constant table;
  - the blank pattern constant 7'h7F.
- One sub-module, hex7seg: combinational nibble-to-a2g decoder, instantiated once on the selected nibble.

## Test plan
Parameters for simulation: SCAN_DIV=4, REFRESH=32, AUTO_TICKS=16, DIGITS=8.
- Reset, then release clr → an cycles FE,FD,…,7F every 4 cycles; data digits show 0; dp=1.
- Manual: ShowMem=0, Addr=5, RegData=32'h00ABCDEF → ReadReg=5 at ISSUE; buffer=ABCDEF 3 edges after the change; address digits show "05".
- Memory with wrap: ShowMem=1, Auto=1 → CurAddr steps 0,1,…,63,0 every 16 cycles; dp low on digit 6.
- Register wrap: ShowMem=0, Auto=1 → CurAddr goes 31→0, never reaching 32.
- Freeze=1 while auto → CurAddr constant; ReadMem/ReadReg stay 0; scan continues. Release → stepping resumes from the held value.
- Assert clr in CAPTURE with MemData=32'hFFFF → buffer stays at its previous value (0 after reset); outputs return to reset values asynchronously.

Source files
------------

// File: rtl/display_pkg.sv
// Purpose: shared FSM state type and segment constants for the debug display scanner.
// Latency: n/a (types and constants only).
// Backpressure: none.
package display_pkg;

  // Snapshot sequencer states.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } snap_state_t;

  // All segments off (common-anode, active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit to segments g..a, active-low.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// Purpose: nibble to 7-segment (g..a, active-low) decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: nib - hex value in; seg - segment pattern out.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/debug_display_scanner.sv
// Purpose: snapshots register-file or data-memory words and scans them, with the
//          address, onto a multiplexed common-anode 7-segment display.
// Latency: address change to buffer update 3 edges; scan outputs registered (1 cycle).
// Backpressure: none; Freeze stalls stepping/refresh, scanning never stops.
// Ports: clk/clr (async active-low reset); ShowMem, Auto, Freeze, Addr control;
//        RegData/MemData read data in; ReadReg/ReadMem read addresses out;
//        CurAddr shown address; a2g/an/dp display drive (all active-low).
// Option: define DISPLAY_BLANK_EN to blank leading-zero data digits.
module debug_display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int MEM_AW     = 6,
  parameter int REG_AW     = 5,
  parameter int DATA_W     = 32,
  parameter int SCAN_DIV   = 50000,
  parameter int REFRESH    = 1000000,
  parameter int AUTO_TICKS = 50000000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ShowMem,
  input  logic              Auto,
  input  logic              Freeze,
  input  logic [MEM_AW-1:0] Addr,
  input  logic [DATA_W-1:0] RegData,
  input  logic [DATA_W-1:0] MemData,
  output logic [REG_AW-1:0] ReadReg,
  output logic [MEM_AW-1:0] ReadMem,
  output logic [MEM_AW-1:0] CurAddr,
  output logic [6:0]        a2g,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int DW4 = 4 * (DIGITS - 2);
  localparam int DIW = $clog2(DIGITS);
  localparam int PW  = $clog2(SCAN_DIV + 1);
  localparam int RW  = $clog2(REFRESH + 1);
  localparam int TW  = $clog2(AUTO_TICKS + 1);
  localparam logic [MEM_AW-1:0] REG_MASK = MEM_AW'((64'd1 << REG_AW) - 64'd1);

  snap_state_t       state_q, state_d;
  logic [MEM_AW-1:0] auto_addr, auto_addr_d, cur, cur_d, issue_addr, addr_mask;
  logic [TW-1:0]     tick_cnt;
  logic [RW-1:0]     ref_cnt;
  logic              show_prev, auto_prev, refresh_pend, issue_src;
  logic              auto_clear, auto_step, ref_hit, go;
  logic [DATA_W-1:0] buf_data;
  logic [MEM_AW-1:0] buf_addr;
  logic              buf_src;
  logic [PW-1:0]     presc;
  logic [DIW-1:0]    digit;

  // Address source and snapshot trigger. The latched read address is the
  // post-edge value (cur_d), so an auto step coinciding with a refresh issues
  // once with the new address. Address/source changes are level-compared
  // against the last issue, so they stay pending through ISSUE/CAPTURE; only
  // the one-cycle refresh pulse needs an explicit pending flag.
  always_comb begin
    addr_mask   = ShowMem ? '1 : REG_MASK;
    auto_clear  = (ShowMem != show_prev) || (Auto && !auto_prev);
    auto_step   = Auto && !Freeze && !auto_clear && (tick_cnt == TW'(AUTO_TICKS - 1));
    ref_hit     = !Freeze && (ref_cnt == RW'(REFRESH - 1));
    auto_addr_d = auto_addr;
    if (auto_clear)     auto_addr_d = '0;
    else if (auto_step) auto_addr_d = (auto_addr + 1'b1) & addr_mask;
    cur   = Auto ? auto_addr   : (Addr & addr_mask);
    cur_d = Auto ? auto_addr_d : (Addr & addr_mask);
    go    = (state_q == HOLD) && !Freeze &&
            (refresh_pend || ref_hit || (cur != issue_addr) || (ShowMem != issue_src));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= HOLD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (go) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  assign ReadReg = (state_q == ISSUE && !issue_src) ? issue_addr[REG_AW-1:0] : '0;
  assign ReadMem = (state_q == ISSUE &&  issue_src) ? issue_addr : '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      auto_addr    <= '0;
      tick_cnt     <= '0;
      ref_cnt      <= '0;
      show_prev    <= 1'b0;
      auto_prev    <= 1'b0;
      refresh_pend <= 1'b0;
      issue_addr   <= '0;
      issue_src    <= 1'b0;
      buf_data     <= '0;
      buf_addr     <= '0;
      buf_src      <= 1'b0;
      CurAddr      <= '0;
    end else begin
      show_prev <= ShowMem;
      auto_prev <= Auto;
      auto_addr <= auto_addr_d;
      CurAddr   <= cur;
      if (auto_clear)             tick_cnt <= '0;
      else if (Auto && !Freeze)   tick_cnt <= auto_step ? '0 : tick_cnt + 1'b1;
      if (!Freeze)                ref_cnt  <= ref_hit ? '0 : ref_cnt + 1'b1;
      refresh_pend <= (refresh_pend || ref_hit) && !go;
      if (go) begin
        issue_addr <= cur_d;
        issue_src  <= ShowMem;
      end
      if (state_q == CAPTURE) begin
        buf_data <= issue_src ? MemData : RegData;
        buf_addr <= issue_addr;
        buf_src  <= issue_src;
      end
    end
  end

  // Display vector: data nibbles zero-extended/truncated to the data digits,
  // address padded to two nibbles on top.
  logic [DW4-1:0] data_ext;
  logic [7:0]     addr8;

  if (DATA_W >= DW4) begin : g_data_trunc
    assign data_ext = buf_data[DW4-1:0];
    if (DATA_W > DW4) begin : g_data_hi
      logic unused_data_hi;
      assign unused_data_hi = ^buf_data[DATA_W-1:DW4];
    end
  end else begin : g_data_pad
    assign data_ext = {{(DW4 - DATA_W){1'b0}}, buf_data};
  end

  if (MEM_AW >= 8) begin : g_addr_trunc
    assign addr8 = buf_addr[7:0];
    if (MEM_AW > 8) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^buf_addr[MEM_AW-1:8];
    end
  end else begin : g_addr_pad
    assign addr8 = {{(8 - MEM_AW){1'b0}}, buf_addr};
  end

  logic [4*DIGITS-1:0] disp_vec;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic                blank;

  assign disp_vec = {addr8, data_ext};

`ifdef DISPLAY_BLANK_EN
  // lead_zero[i]: data nibble i and every nibble above it are zero.
  logic [DIGITS-1:0] lead_zero;
  always_comb begin : p_lead_zero
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 3; i >= 0; i--) begin
      run          = run && (data_ext[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end
`endif

  always_comb begin
    nib   = '0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit == DIW'(i)) begin
        nib = disp_vec[4*i +: 4];
`ifdef DISPLAY_BLANK_EN
        blank = (i > 0) && (i < DIGITS - 2) && lead_zero[i];
`endif
      end
    end
  end

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (seg)
  );

  // Scan: segments, anode and dp are registered together so they switch on
  // the same edge (no ghosting between digits).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc <= '0;
      digit <= '0;
      an    <= '1;
      a2g   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        digit <= (digit == DIW'(DIGITS - 1)) ? '0 : digit + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      an  <= ~(DIGITS'(1) << digit);
      a2g <= blank ? SEG_BLANK : seg;
      dp  <= !(buf_src && (digit == DIW'(DIGITS - 2)));
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
module tb_debug_display_scanner;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        ShowMem = 1'b0;
  logic        Auto = 1'b0;
  logic        Freeze = 1'b0;
  logic [5:0]  Addr = '0;
  logic [31:0] RegData = '0;
  logic [31:0] MemData = '0;
  logic [4:0]  ReadReg;
  logic [5:0]  ReadMem;
  logic [5:0]  CurAddr;
  logic [6:0]  a2g;
  logic [7:0]  an;
  logic        dp;

  int vectors = 0;
  int errors  = 0;
  int m       = 0;   // unfrozen edges since the last auto-address clear

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  // Segments lit (active-high, g..a) for each hex digit.
  localparam logic [6:0] SEG_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  debug_display_scanner #(
    .DIGITS(8), .MEM_AW(6), .REG_AW(5), .DATA_W(32),
    .SCAN_DIV(4), .REFRESH(32), .AUTO_TICKS(16)
  ) dut (
    .clk(clk), .clr(clr), .ShowMem(ShowMem), .Auto(Auto), .Freeze(Freeze),
    .Addr(Addr), .RegData(RegData), .MemData(MemData),
    .ReadReg(ReadReg), .ReadMem(ReadMem), .CurAddr(CurAddr),
    .a2g(a2g), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file and data memory.
  always @(posedge clk) begin
    RegData <= regs[ReadReg];
    MemData <= mem[ReadMem];
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pattern on digit d: 6 data digits (low 24 bits), then address lo/hi.
  function automatic logic [6:0] exp_seg(int d, logic [31:0] data, logic [7:0] addr);
    logic [23:0] shown;
    logic [3:0]  nib;
    shown = data[23:0];
    if (d >= 6) nib = 4'((addr >> (4 * (d - 6))) & 8'hF);
    else        nib = 4'((shown >> (4 * d)) & 24'hF);
`ifdef DISPLAY_BLANK_EN
    if (d >= 1 && d <= 5 && (shown >> (4 * d)) == 24'd0) return 7'h7F;
`endif
    return ~SEG_ON[nib];
  endfunction

  task automatic test_reset();
    clr = 1'b0; ShowMem = 1'b0; Auto = 1'b0; Freeze = 1'b0; Addr = '0;
    repeat (3) tick();
    vectors++;
    if (an !== 8'hFF || a2g !== 7'h7F || dp !== 1'b1 || ReadReg !== 5'd0 ||
        ReadMem !== 6'd0 || CurAddr !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs: an=%h a2g=%h dp=%b rr=%0d rm=%0d cur=%0d, required an=ff a2g=7f dp=1 rr=0 rm=0 cur=0",
               an, a2g, dp, ReadReg, ReadMem, CurAddr);
    end
    clr = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      int d;
      tick();
      d = ((k - 1) / 4) % 8;
      vectors++;
      if (an !== ~(8'd1 << d) || a2g !== exp_seg(d, 32'd0, 8'd0) || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_scan k=%0d: an=%h a2g=%h dp=%b, required an=%h a2g=%h dp=1",
                 k, an, a2g, dp, ~(8'd1 << d), exp_seg(d, 32'd0, 8'd0));
      end
    end
  endtask

  task automatic test_manual();
    for (int it = 0; it < 6; it++) begin
      logic        sm, seen;
      logic [5:0]  a, c;
      logic [31:0] data;
      if (it == 0) begin
        sm = 1'b0; a = 6'd5; regs[5] = 32'h00ABCDEF;
      end else begin
        sm = 1'($urandom_range(0, 1));
        a  = 6'($urandom_range(1, 63));
        if (!sm && a[4:0] == 5'd0) a[0] = 1'b1;
      end
      c = sm ? a : {1'b0, a[4:0]};
      ShowMem = sm; Addr = a;
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        tick();
        seen = sm ? (ReadMem === c && ReadReg === 5'd0)
                  : (ReadReg === c[4:0] && ReadMem === 6'd0);
      end
      vectors++;
      if (!seen) begin
        errors++;
        $display("FAIL manual_issue it=%0d: rr=%0d rm=%0d, required read of %0d on %s port within 40 cycles",
                 it, ReadReg, ReadMem, c, sm ? "mem" : "reg");
      end
      tick();
      vectors++;
      if (ReadReg !== 5'd0 || ReadMem !== 6'd0) begin
        errors++;
        $display("FAIL manual_capture_ports it=%0d: rr=%0d rm=%0d, required 0 0", it, ReadReg, ReadMem);
      end
      tick(); tick();
      vectors++;
      if (CurAddr !== c) begin
        errors++;
        $display("FAIL manual_curaddr it=%0d: got %0d, required %0d", it, CurAddr, c);
      end
      data = sm ? mem[c] : regs[c[4:0]];
      for (int k = 0; k < 36; k++) begin
        int dd;
        tick();
        dd = -1;
        for (int i = 0; i < 8; i++) if (an[i] == 1'b0) dd = i;
        vectors++;
        if ($countones(~an) != 1 || dd < 0 || a2g !== exp_seg(dd, data, {2'b00, c}) ||
            dp !== !(sm && dd == 6)) begin
          errors++;
          $display("FAIL manual_display it=%0d: an=%h a2g=%h dp=%b, required a2g=%h dp=%b for data %h addr %0d",
                   it, an, a2g, dp, (dd < 0) ? 7'h7F : exp_seg(dd, data, {2'b00, c}),
                   !(sm && dd == 6), data, c);
        end
      end
    end
  endtask

  task automatic test_auto_mem_wrap();
    ShowMem = 1'b1; Addr = '0; Freeze = 1'b0; Auto = 1'b1;
    tick();          // edge that clears the auto address
    m = 0;
    for (int n = 1; n <= 16 * 65 + 4; n++) begin
      int ex;
      ex = (m / 16) % 64;
      tick();
      m++;
      vectors++;
      if (CurAddr !== 6'(ex)) begin
        errors++;
        $display("FAIL mem_auto_step n=%0d: CurAddr=%0d, required %0d", n, CurAddr, ex);
      end
    end
    for (int k = 0; k < 36; k++) begin
      tick();
      vectors++;
      if (dp !== an[6]) begin
        errors++;
        $display("FAIL mem_dp: an=%h dp=%b, required dp=%b", an, dp, an[6]);
      end
    end
  endtask

  task automatic test_auto_reg_wrap();
    ShowMem = 1'b0;
    tick();          // source change clears the auto address
    m = 0;
    for (int n = 1; n <= 16 * 34; n++) begin
      int ex;
      ex = (m / 16) % 32;
      tick();
      m++;
      vectors++;
      if (CurAddr !== 6'(ex)) begin
        errors++;
        $display("FAIL reg_auto_step n=%0d: CurAddr=%0d, required %0d", n, CurAddr, ex);
      end
    end
  endtask

  task automatic test_freeze();
    int d0;
    Freeze = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int ex;
      ex = (m / 16) % 32;
      tick();
      vectors++;
      if (CurAddr !== 6'(ex)) begin
        errors++;
        $display("FAIL freeze_hold n=%0d: CurAddr=%0d, required %0d", n, CurAddr, ex);
      end
      if (n >= 3) begin
        vectors++;
        if (ReadReg !== 5'd0 || ReadMem !== 6'd0) begin
          errors++;
          $display("FAIL freeze_no_issue n=%0d: rr=%0d rm=%0d, required 0 0", n, ReadReg, ReadMem);
        end
      end
    end
    d0 = 0;
    for (int i = 0; i < 8; i++) if (an[i] == 1'b0) d0 = i;
    repeat (8) tick();
    vectors++;
    if (an !== ~(8'd1 << ((d0 + 2) % 8))) begin
      errors++;
      $display("FAIL freeze_scan: an=%h, required %h", an, ~(8'd1 << ((d0 + 2) % 8)));
    end
    Freeze = 1'b0;
    for (int n = 0; n < 48; n++) begin
      int ex;
      ex = (m / 16) % 32;
      tick();
      m++;
      vectors++;
      if (CurAddr !== 6'(ex)) begin
        errors++;
        $display("FAIL freeze_resume n=%0d: CurAddr=%0d, required %0d", n, CurAddr, ex);
      end
    end
  endtask

  task automatic test_clr_in_capture();
    logic seen;
    Auto = 1'b0; Freeze = 1'b0; ShowMem = 1'b0; Addr = '0;
    clr = 1'b0; tick(); clr = 1'b1;
    tick(); tick();
    mem[3] = 32'h0000FFFF;
    ShowMem = 1'b1; Addr = 6'd3;
    seen = 1'b0;
    for (int w = 0; w < 40 && !seen; w++) begin
      tick();
      seen = (ReadMem === 6'd3);
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL clr_issue: rm=%0d, required 3 within 40 cycles", ReadMem);
    end
    tick();          // CAPTURE cycle, memory data now presented
    clr = 1'b0;
    #1;
    vectors++;
    if (an !== 8'hFF || a2g !== 7'h7F || dp !== 1'b1 || ReadReg !== 5'd0 ||
        ReadMem !== 6'd0 || CurAddr !== 6'd0) begin
      errors++;
      $display("FAIL clr_async: an=%h a2g=%h dp=%b rr=%0d rm=%0d cur=%0d, required an=ff a2g=7f dp=1 rr=0 rm=0 cur=0",
               an, a2g, dp, ReadReg, ReadMem, CurAddr);
    end
    tick();
    ShowMem = 1'b0; Addr = '0; clr = 1'b1;
    for (int k = 0; k < 36; k++) begin
      int dd;
      tick();
      dd = -1;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) dd = i;
      vectors++;
      if (dd < 0 || a2g !== exp_seg(dd, 32'd0, 8'd0) || dp !== 1'b1) begin
        errors++;
        $display("FAIL clr_buffer: an=%h a2g=%h dp=%b, required a2g=%h dp=1 (empty buffer)",
                 an, a2g, dp, (dd < 0) ? 7'h7F : exp_seg(dd, 32'd0, 8'd0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    regs[0] = 32'd0;
    test_reset();
    test_manual();
    test_auto_mem_wrap();
    test_auto_reg_wrap();
    test_freeze();
    test_clr_in_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
